dcache_port_arbiter: RTL and testbench

- Shares the single dcache request port between the store queue's committed-store drain and NUM_LD load-FU requesters.
- Holds one registered outgoing request with a valid/ready handshake to dcache.
- Loads get priority for latency; a saturating starvation counter and SQ back-pressure force stores through.
- A drain FSM, used before halt, stops loads and empties all stores.

---
 rtl/dcache_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single dcache request port between committed-store drain and
// NUM_LD load requesters; one registered outgoing request with valid/ready.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// ST_NORMAL | loads preferred, store forced by starvation or SQ pressure
// ST_DRAIN  | loads blocked, stores issued until SQ and port are empty
// ST_DONE   | drain complete, drain_done high, nothing accepted
module dcache_port_arbiter #(
  parameter int NUM_LD       = 2,
  parameter int LD_ID_BITS   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   st_req_valid,
  input  logic [31:0]            st_req_addr,
  input  logic [1:0]             st_req_size,
  input  logic [31:0]            st_req_data,
  output logic                   st_req_accept,
  input  logic [NUM_LD-1:0]      ld_req_valid,
  input  logic [NUM_LD*32-1:0]   ld_req_addr,
  input  logic [NUM_LD*2-1:0]    ld_req_size,
  output logic [NUM_LD-1:0]      ld_req_accept,
  input  logic                   sq_almost_full,
  input  logic                   sq_empty,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic                   mem_valid,
  output logic                   mem_is_store,
  output logic [31:0]            mem_addr,
  output logic [1:0]             mem_size,
  output logic [31:0]            mem_data,
  output logic [LD_ID_BITS-1:0]  mem_ld_id,
  input  logic                   mem_ready
);

  typedef enum logic [1:0] {ST_NORMAL, ST_DRAIN, ST_DONE} state_t;

  localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(STARVE_LIMIT);

  state_t                  state_q, state_d;
  logic [LD_ID_BITS-1:0]   rr_ptr;
  logic [LD_ID_BITS-1:0]   rr_next;
  logic [CNT_BITS-1:0]     starve_cnt;

  logic                    can_load;
  logic                    st_pref;
  logic                    grant_st;
  logic                    grant_ld;
  logic                    ld_found;
  logic [LD_ID_BITS-1:0]   ld_sel;
  logic [NUM_LD-1:0]       ld_rot;
  logic [2*NUM_LD-1:0]     ld_dbl;
  logic [31:0]             sel_addr;
  logic [1:0]              sel_size;
  int                      win;

  assign can_load = !mem_valid || mem_ready;
  assign ld_dbl   = {ld_req_valid, ld_req_valid};

  // Rotate the valid vector so bit 0 is the requester at rr_ptr, then take
  // the first set bit; this is the round-robin search from rr_ptr upward.
  always_comb begin
    ld_rot   = NUM_LD'(ld_dbl >> rr_ptr);
    ld_found = 1'b0;
    ld_sel   = '0;
    win      = 0;
    for (int i = 0; i < NUM_LD; i++) begin
      if (!ld_found && ld_rot[i]) begin
        ld_found = 1'b1;
        win      = int'(rr_ptr) + i;
        if (win >= NUM_LD) win = win - NUM_LD;
        ld_sel   = LD_ID_BITS'(win);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_size = '0;
    for (int k = 0; k < NUM_LD; k++) begin
      if (ld_sel == LD_ID_BITS'(k)) begin
        sel_addr = ld_req_addr[k*32 +: 32];
        sel_size = ld_req_size[k*2 +: 2];
      end
    end
  end

  assign rr_next = (ld_sel == LD_ID_BITS'(NUM_LD - 1)) ? '0 : ld_sel + LD_ID_BITS'(1);

  assign st_pref = st_req_valid &&
                   (sq_almost_full || (starve_cnt == CNT_MAX) || !(|ld_req_valid));

  always_comb begin
    grant_st = 1'b0;
    grant_ld = 1'b0;
    if (reset && can_load) begin
      case (state_q)
        ST_NORMAL: begin
          if (st_pref)       grant_st = 1'b1;
          else if (ld_found) grant_ld = 1'b1;
        end
        ST_DRAIN: grant_st = st_req_valid;
        default: ;
      endcase
    end
  end

  assign st_req_accept = grant_st;
  assign ld_req_accept = grant_ld ? (NUM_LD'(1) << ld_sel) : '0;

  // The in-flight store must handshake before the drain is considered done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req)
          state_d = ST_NORMAL;
        else if (sq_empty && !st_req_valid && !(mem_valid && mem_is_store))
          state_d = ST_DONE;
      end
      ST_DONE: if (!drain_req) state_d = ST_NORMAL;
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_NORMAL;
      drain_done <= 1'b0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      state_q    <= state_d;
      drain_done <= (state_q == ST_DONE) && (state_d == ST_DONE);
      if (grant_ld) rr_ptr <= rr_next;
      if (grant_st)
        starve_cnt <= '0;
      else if (st_req_valid && (starve_cnt != CNT_MAX))
        starve_cnt <= starve_cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_valid    <= 1'b0;
      mem_is_store <= 1'b0;
      mem_addr     <= '0;
      mem_size     <= '0;
      mem_data     <= '0;
      mem_ld_id    <= '0;
    end else if (can_load) begin
      if (grant_st) begin
        mem_valid    <= 1'b1;
        mem_is_store <= 1'b1;
        mem_addr     <= st_req_addr;
        mem_size     <= st_req_size;
        mem_data     <= st_req_data;
        mem_ld_id    <= '0;
      end else if (grant_ld) begin
        mem_valid    <= 1'b1;
        mem_is_store <= 1'b0;
        mem_addr     <= sel_addr;
        mem_size     <= sel_size;
        mem_data     <= '0;
        mem_ld_id    <= ld_sel;
      end else begin
        mem_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_dcache_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        st_req_valid;
  logic [31:0] st_req_addr;
  logic [1:0]  st_req_size;
  logic [31:0] st_req_data;
  logic        st_req_accept;
  logic [1:0]  ld_req_valid;
  logic [63:0] ld_req_addr;
  logic [3:0]  ld_req_size;
  logic [1:0]  ld_req_accept;
  logic        sq_almost_full;
  logic        sq_empty;
  logic        drain_req;
  logic        drain_done;
  logic        mem_valid;
  logic        mem_is_store;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_data;
  logic [0:0]  mem_ld_id;
  logic        mem_ready;

  localparam logic [31:0] ST_ADDR = 32'h0000_1000;
  localparam logic [31:0] ST_DATA = 32'hDEAD_BEEF;
  localparam logic [1:0]  ST_SIZE = 2'd2;
  localparam logic [31:0] L0_ADDR = 32'h0000_2000;
  localparam logic [1:0]  L0_SIZE = 2'd1;
  localparam logic [31:0] L1_ADDR = 32'h0000_3004;
  localparam logic [1:0]  L1_SIZE = 2'd3;

  dcache_port_arbiter #(.NUM_LD(2), .LD_ID_BITS(1), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_size(st_req_size),
    .st_req_data(st_req_data), .st_req_accept(st_req_accept),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_size(ld_req_size),
    .ld_req_accept(ld_req_accept),
    .sq_almost_full(sq_almost_full), .sq_empty(sq_empty),
    .drain_req(drain_req), .drain_done(drain_done),
    .mem_valid(mem_valid), .mem_is_store(mem_is_store), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_data(mem_data), .mem_ld_id(mem_ld_id),
    .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       st_v;
    logic [1:0] ld_v;
    logic       af;
    logic       emp;
    logic       drn;
    logic       rdy;
    logic       e_st;
    logic [1:0] e_ld;
    logic       e_mv;
    logic       e_is;
    logic       e_id;
    logic       e_dd;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(logic st_v, logic [1:0] ld_v, logic af, logic emp, logic drn,
                              logic rdy, logic e_st, logic [1:0] e_ld, logic e_mv,
                              logic e_is, logic e_id, logic e_dd);
    vec_t v;
    v.st_v = st_v; v.ld_v = ld_v; v.af = af; v.emp = emp; v.drn = drn; v.rdy = rdy;
    v.e_st = e_st; v.e_ld = e_ld; v.e_mv = e_mv; v.e_is = e_is; v.e_id = e_id; v.e_dd = e_dd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input logic is_st, input logic id);
    logic [31:0] ea;
    logic [1:0]  es;
    logic [31:0] ed;
    ea = is_st ? ST_ADDR : (id ? L1_ADDR : L0_ADDR);
    es = is_st ? ST_SIZE : (id ? L1_SIZE : L0_SIZE);
    ed = is_st ? ST_DATA : 32'h0;
    chk({tag, " mem_is_store"}, 32'(mem_is_store), 32'(is_st));
    chk({tag, " mem_ld_id"},    32'(mem_ld_id),    32'(is_st ? 1'b0 : id));
    chk({tag, " mem_addr"},     mem_addr,          ea);
    chk({tag, " mem_size"},     32'(mem_size),     32'(es));
    chk({tag, " mem_data"},     mem_data,          ed);
  endtask

  task automatic drive_idle();
    st_req_valid = 1'b0; ld_req_valid = 2'b00; sq_almost_full = 1'b0;
    sq_empty = 1'b1; drain_req = 1'b0; mem_ready = 1'b1;
  endtask

  initial begin
    st_req_addr = ST_ADDR; st_req_data = ST_DATA; st_req_size = ST_SIZE;
    ld_req_addr = {L1_ADDR, L0_ADDR};
    ld_req_size = {L1_SIZE, L0_SIZE};

    // Reset held low with every request valid.
    reset = 1'b0;
    drive_idle();
    st_req_valid = 1'b1; ld_req_valid = 2'b11;
    repeat (2) @(negedge clock);
    #1;
    chk("rst mem_valid",     32'(mem_valid),     0);
    chk("rst st_accept",     32'(st_req_accept), 0);
    chk("rst ld_accept",     32'(ld_req_accept), 0);
    chk("rst drain_done",    32'(drain_done),    0);
    chk("rst mem_addr",      mem_addr,           0);

    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("post-rst ld_accept", 32'(ld_req_accept), 32'h1);
    chk("post-rst st_accept", 32'(st_req_accept), 0);
    @(negedge clock);
    #1;
    chk("post-rst mem_valid", 32'(mem_valid), 1);
    chk_mem("post-rst", 1'b0, 1'b0);

    // Reset in flight drops the request immediately.
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst mem_valid", 32'(mem_valid),     0);
    chk("midrst ld_accept", 32'(ld_req_accept), 0);
    chk("midrst st_accept", 32'(st_req_accept), 0);
    drive_idle();
    @(negedge clock);
    reset = 1'b1;

    //   st  ld     af   emp  drn  rdy | e_st e_ld  e_mv e_is e_id e_dd
    // round robin
    add(0, 2'b11, 0, 1, 0, 1,  0, 2'b01, 0, 0, 0, 0);
    add(0, 2'b11, 0, 1, 0, 1,  0, 2'b10, 1, 0, 0, 0);
    add(0, 2'b11, 0, 1, 0, 1,  0, 2'b01, 1, 0, 1, 0);
    add(0, 2'b11, 0, 1, 0, 1,  0, 2'b10, 1, 0, 0, 0);
    // starvation: four load grants then the store is forced
    add(1, 2'b11, 0, 0, 0, 1,  0, 2'b01, 1, 0, 1, 0);
    add(1, 2'b11, 0, 0, 0, 1,  0, 2'b10, 1, 0, 0, 0);
    add(1, 2'b11, 0, 0, 0, 1,  0, 2'b01, 1, 0, 1, 0);
    add(1, 2'b11, 0, 0, 0, 1,  0, 2'b10, 1, 0, 0, 0);
    add(1, 2'b11, 0, 0, 0, 1,  1, 2'b00, 1, 0, 1, 0);
    add(1, 2'b11, 0, 0, 0, 1,  0, 2'b01, 1, 1, 0, 0);
    add(0, 2'b11, 0, 1, 0, 1,  0, 2'b10, 1, 0, 0, 0);
    // back-pressure for three cycles, then same-cycle refill
    add(0, 2'b11, 0, 1, 0, 0,  0, 2'b00, 1, 0, 1, 0);
    add(0, 2'b11, 0, 1, 0, 0,  0, 2'b00, 1, 0, 1, 0);
    add(0, 2'b11, 0, 1, 0, 0,  0, 2'b00, 1, 0, 1, 0);
    add(0, 2'b11, 0, 1, 0, 1,  0, 2'b01, 1, 0, 1, 0);
    // lone store clears starve count; then urgent store beats a load
    add(1, 2'b00, 0, 0, 0, 1,  1, 2'b00, 1, 0, 0, 0);
    add(0, 2'b00, 0, 1, 0, 1,  0, 2'b00, 1, 1, 0, 0);
    add(1, 2'b01, 1, 0, 0, 1,  1, 2'b00, 0, 0, 0, 0);
    add(0, 2'b00, 0, 1, 0, 1,  0, 2'b00, 1, 1, 0, 0);
    add(0, 2'b00, 0, 1, 0, 1,  0, 2'b00, 0, 0, 0, 0);
    // drain with two stores and loads pending
    add(0, 2'b00, 0, 0, 1, 1,  0, 2'b00, 0, 0, 0, 0);
    add(1, 2'b11, 0, 0, 1, 1,  1, 2'b00, 0, 0, 0, 0);
    add(1, 2'b11, 0, 0, 1, 1,  1, 2'b00, 1, 1, 0, 0);
    add(0, 2'b11, 0, 1, 1, 1,  0, 2'b00, 1, 1, 0, 0);
    add(0, 2'b11, 0, 1, 1, 1,  0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 0, 1, 1, 1,  0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 0, 1, 0, 1,  0, 2'b00, 0, 0, 0, 1);
    add(0, 2'b11, 0, 1, 0, 1,  0, 2'b10, 0, 0, 0, 0);
    add(0, 2'b00, 0, 1, 0, 1,  0, 2'b00, 1, 0, 1, 0);
    // drain abandoned before completion
    add(0, 2'b00, 0, 0, 1, 1,  0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 0, 0, 1, 1,  0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 0, 0, 0, 1,  0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 0, 1, 0, 1,  0, 2'b01, 0, 0, 0, 0);
    add(0, 2'b00, 0, 1, 0, 1,  0, 2'b00, 1, 0, 0, 0);

    for (int r = 0; r < vecs.size(); r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      @(negedge clock);
      st_req_valid   = vecs[r].st_v;
      ld_req_valid   = vecs[r].ld_v;
      sq_almost_full = vecs[r].af;
      sq_empty       = vecs[r].emp;
      drain_req      = vecs[r].drn;
      mem_ready      = vecs[r].rdy;
      #1;
      chk({tag, " st_accept"},  32'(st_req_accept), 32'(vecs[r].e_st));
      chk({tag, " ld_accept"},  32'(ld_req_accept), 32'(vecs[r].e_ld));
      chk({tag, " mem_valid"},  32'(mem_valid),     32'(vecs[r].e_mv));
      chk({tag, " drain_done"}, 32'(drain_done),    32'(vecs[r].e_dd));
      if (vecs[r].e_mv) chk_mem(tag, vecs[r].e_is, vecs[r].e_id);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
